// File: rtl/mrc_combiner_if.sv
// ----------------------------------------------------------------------------
// mrc_combiner_if -- handshake and data bundle for the two-antenna MRC combiner.
//
// Signals (all synchronous to the combiner clock):
//   start        symbol-open pulse
//   valid_in     qualifies the eight W-bit data inputs
//   hc0_*/hc1_*  conjugated channel estimates, antenna 0/1 (signed, Q.FRAC)
//   y0_*/y1_*    received subcarrier samples, antenna 0/1 (signed, Q.FRAC)
//   z_re, z_im   combined symbol hc0*y0 + hc1*y1 (signed, saturated)
//   pwr          channel power |hc0|^2 + |hc1|^2 (non-negative, saturated)
//   valid_out    qualifies z_re, z_im, pwr, last_out
//   last_out     output of the final subcarrier of a symbol
//   busy         combiner is inside a symbol
//   done         one-cycle symbol-completion pulse
//
// Modports: master drives the inputs (source side), slave is the combiner.
// ----------------------------------------------------------------------------
`ifndef FIXED_POINT_WIDTH
`define FIXED_POINT_WIDTH 16
`endif

interface mrc_combiner_if #(
  parameter int W = `FIXED_POINT_WIDTH
);
  logic                start;
  logic                valid_in;
  logic signed [W-1:0] hc0_re;
  logic signed [W-1:0] hc0_im;
  logic signed [W-1:0] hc1_re;
  logic signed [W-1:0] hc1_im;
  logic signed [W-1:0] y0_re;
  logic signed [W-1:0] y0_im;
  logic signed [W-1:0] y1_re;
  logic signed [W-1:0] y1_im;
  logic signed [W-1:0] z_re;
  logic signed [W-1:0] z_im;
  logic signed [W-1:0] pwr;
  logic                valid_out;
  logic                last_out;
  logic                busy;
  logic                done;

  modport master (
    output start, valid_in,
    output hc0_re, hc0_im, hc1_re, hc1_im,
    output y0_re, y0_im, y1_re, y1_im,
    input  z_re, z_im, pwr, valid_out, last_out, busy, done
  );

  modport slave (
    input  start, valid_in,
    input  hc0_re, hc0_im, hc1_re, hc1_im,
    input  y0_re, y0_im, y1_re, y1_im,
    output z_re, z_im, pwr, valid_out, last_out, busy, done
  );
endinterface

// File: rtl/mrc_combiner.sv
// ----------------------------------------------------------------------------
// mrc_combiner -- two-antenna maximum-ratio combiner.
//
// For every accepted subcarrier computes
//   z   = hc0*y0 + hc1*y1            (complex, full precision)
//   pwr = |hc0|^2 + |hc1|^2
// then scales both by 2^-FRAC (arithmetic shift, floor) and saturates to W bits.
//
// A symbol is NSC subcarriers opened by a start pulse. Datapath: an input
// capture register followed by three arithmetic stages (products, sums,
// shift/saturate), so a sample accepted at edge k is presented after edge k+3.
// No stalls; gaps in valid_in reappear as gaps in valid_out.
//
// Ports:
//   clk  sole clock, rising edge
//   rst  asynchronous active-high reset
//   bus  mrc_combiner_if.slave (start/valid_in/data in, results/status out)
// Parameters:
//   W     word width of all data ports (two's complement)
//   FRAC  fractional bits of every input and output word
//   NSC   subcarriers per symbol (>= 2)
// ----------------------------------------------------------------------------
`ifndef FIXED_POINT_WIDTH
`define FIXED_POINT_WIDTH 16
`endif

module mrc_combiner #(
  parameter int W    = `FIXED_POINT_WIDTH,
  parameter int FRAC = 8,
  parameter int NSC  = 64
) (
  input  logic           clk,
  input  logic           rst,
  mrc_combiner_if.slave  bus
);

  localparam int CW = (NSC > 2) ? $clog2(NSC) : 1;
  localparam int PW = 2*W + 1;   // one complex product or one |h|^2 term
  localparam int SW = 2*W + 2;   // sum over both antennas

  typedef logic signed [W-1:0]  word_t;
  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [SW-1:0] sum_t;

  localparam sum_t MAX_S = sum_t'((64'sd1 <<< (W-1)) - 64'sd1);
  localparam sum_t MIN_S = -sum_t'(64'sd1 <<< (W-1));
  localparam word_t MAX_W = word_t'((64'sd1 <<< (W-1)) - 64'sd1);
  localparam word_t MIN_W = word_t'(-(64'sd1 <<< (W-1)));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  state_t          state;
  logic [CW-1:0]   sc_cnt;
  logic [1:0]      flush_cnt;
  logic            busy_q;
  logic            done_q;

  logic            accept;
  logic            accept_last;

  assign accept      = (state == RUN) && bus.valid_in;
  assign accept_last = accept && (sc_cnt == CW'(NSC - 1));

  // FLUSH covers the three edges the final sample needs to reach the output
  // register, plus the cycle in which it is presented. done is raised for that
  // presentation cycle so it lines up with last_out; busy drops one cycle later.
  // NOTE: every register here is written with <= so all of them see the
  // pre-edge values; a blocking write would let later statements see the new
  // state within the same edge and break the FSM's timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sc_cnt    <= '0;
      flush_cnt <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // start with a simultaneous valid_in opens the symbol; that sample
          // is not taken because accept requires state == RUN.
          if (bus.start) begin
            state  <= RUN;
            sc_cnt <= '0;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (accept_last) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end else if (accept) begin
            sc_cnt <= sc_cnt + CW'(1);
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 2'd1;
          if (flush_cnt == 2'd2) begin
            done_q <= 1'b1;
          end
          if (flush_cnt == 2'd3) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath qualifiers (reset so a reset drops all in-flight samples)
  // --------------------------------------------------------------------------
  logic v_cap,  l_cap;
  logic v_prod, l_prod;
  logic v_sum,  l_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_cap  <= 1'b0;
      l_cap  <= 1'b0;
      v_prod <= 1'b0;
      l_prod <= 1'b0;
      v_sum  <= 1'b0;
      l_sum  <= 1'b0;
    end else begin
      v_cap  <= accept;
      l_cap  <= accept_last;
      v_prod <= v_cap;
      l_prod <= l_cap;
      v_sum  <= v_prod;
      l_sum  <= l_prod;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath payload
  // --------------------------------------------------------------------------
  word_t c_h0r, c_h0i, c_h1r, c_h1i;
  word_t c_y0r, c_y0i, c_y1r, c_y1i;
  prod_t p0_re, p0_im, p1_re, p1_im, p0_pw, p1_pw;
  sum_t  s_re, s_im, s_pw;

  // NOTE: payload registers carry no reset; they are only ever observed
  // through the reset-cleared valid bits, so their contents after reset are
  // irrelevant and a reset network on them would buy nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      c_h0r <= bus.hc0_re;
      c_h0i <= bus.hc0_im;
      c_h1r <= bus.hc1_re;
      c_h1i <= bus.hc1_im;
      c_y0r <= bus.y0_re;
      c_y0i <= bus.y0_im;
      c_y1r <= bus.y1_re;
      c_y1i <= bus.y1_im;
    end

    // Stage 1: per-antenna complex products and power terms.
    p0_re <= prod_t'(c_h0r) * prod_t'(c_y0r) - prod_t'(c_h0i) * prod_t'(c_y0i);
    p0_im <= prod_t'(c_h0r) * prod_t'(c_y0i) + prod_t'(c_h0i) * prod_t'(c_y0r);
    p1_re <= prod_t'(c_h1r) * prod_t'(c_y1r) - prod_t'(c_h1i) * prod_t'(c_y1i);
    p1_im <= prod_t'(c_h1r) * prod_t'(c_y1i) + prod_t'(c_h1i) * prod_t'(c_y1r);
    p0_pw <= prod_t'(c_h0r) * prod_t'(c_h0r) + prod_t'(c_h0i) * prod_t'(c_h0i);
    p1_pw <= prod_t'(c_h1r) * prod_t'(c_h1r) + prod_t'(c_h1i) * prod_t'(c_h1i);

    // Stage 2: combine antennas.
    s_re <= sum_t'(p0_re) + sum_t'(p1_re);
    s_im <= sum_t'(p0_im) + sum_t'(p1_im);
    s_pw <= sum_t'(p0_pw) + sum_t'(p1_pw);
  end

  // Two-sided saturation of an already-scaled sum.
  function automatic word_t sat_w(input sum_t v);
    if (v > MAX_S)      return MAX_W;
    else if (v < MIN_S) return MIN_W;
    else                return v[W-1:0];
  endfunction

  // Power is a sum of squares, so only the upper bound can be hit.
  function automatic word_t sat_pos(input sum_t v);
    if (v > MAX_S) return MAX_W;
    else           return v[W-1:0];
  endfunction

  // Stage 3: scale, saturate, and force zero on idle cycles.
  word_t z_re_q, z_im_q, pwr_q;
  logic  valid_q, last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_re_q  <= '0;
      z_im_q  <= '0;
      pwr_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= v_sum;
      last_q  <= v_sum && l_sum;
      z_re_q  <= v_sum ? sat_w(s_re >>> FRAC)  : '0;
      z_im_q  <= v_sum ? sat_w(s_im >>> FRAC)  : '0;
      pwr_q   <= v_sum ? sat_pos(s_pw >>> FRAC) : '0;
    end
  end

  assign bus.z_re      = z_re_q;
  assign bus.z_im      = z_im_q;
  assign bus.pwr       = pwr_q;
  assign bus.valid_out = valid_q;
  assign bus.last_out  = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mrc_combiner.sv
// ----------------------------------------------------------------------------
// tb_mrc_combiner -- self-checking bench for mrc_combiner (W=16, FRAC=8, NSC=4).
//
// A reference model tracks symbols at transaction level (open / count of
// accepted subcarriers / draining) and computes each result with plain 64-bit
// arithmetic, posting it three edges after acceptance. A monitor on the falling
// edge compares every output of every cycle against that schedule. Directed
// vectors with hand-computed constants, a gapped symbol, a mid-symbol reset and
// a long randomized run feed it.
// ----------------------------------------------------------------------------
module tb_mrc_combiner;

  localparam int W    = 16;
  localparam int FRAC = 8;
  localparam int NSC  = 4;
  localparam int EXP_N = 8192;
  localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W-1));

  typedef logic signed [W-1:0] word_t;

  typedef struct {
    word_t h0r, h0i, y0r, y0i, h1r, h1i, y1r, y1i;
  } smp_t;

  typedef struct {
    bit     v;
    bit     last;
    bit     done;
    longint re;
    longint im;
    longint pwr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mrc_combiner_if #(.W(W)) bus ();

  mrc_combiner #(.W(W), .FRAC(FRAC), .NSC(NSC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n     = 0;   // index of the most recent rising edge

  task automatic check(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, want, n);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference arithmetic
  // --------------------------------------------------------------------------
  function automatic longint sat(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic exp_t ref_calc(input smp_t s);
    exp_t   e;
    longint re, im, pw;
    re = longint'(s.h0r) * s.y0r - longint'(s.h0i) * s.y0i
       + longint'(s.h1r) * s.y1r - longint'(s.h1i) * s.y1i;
    im = longint'(s.h0r) * s.y0i + longint'(s.h0i) * s.y0r
       + longint'(s.h1r) * s.y1i + longint'(s.h1i) * s.y1r;
    pw = longint'(s.h0r) * s.h0r + longint'(s.h0i) * s.h0i
       + longint'(s.h1r) * s.h1r + longint'(s.h1i) * s.h1i;
    e.v    = 1'b1;
    e.last = 1'b0;
    e.done = 1'b0;
    e.re   = sat(re >>> FRAC);
    e.im   = sat(im >>> FRAC);
    e.pwr  = sat(pw >>> FRAC);
    return e;
  endfunction

  function automatic smp_t cur_smp();
    smp_t s;
    s.h0r = bus.hc0_re; s.h0i = bus.hc0_im;
    s.h1r = bus.hc1_re; s.h1i = bus.hc1_im;
    s.y0r = bus.y0_re;  s.y0i = bus.y0_im;
    s.y1r = bus.y1_re;  s.y1i = bus.y1_im;
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Transaction-level model: expected outputs per edge
  // --------------------------------------------------------------------------
  exp_t ex      [EXP_N];
  bit   ex_busy [EXP_N];
  bit   m_open  = 1'b0;
  bit   m_drain = 1'b0;
  int   m_cnt   = 0;
  int   m_end   = 0;
  int   m_syms  = 0;

  always @(posedge clk) begin : model
    bit   was_open, was_drain;
    exp_t e;
    n = n + 1;
    was_open  = m_open;
    was_drain = m_drain;
    if (rst) begin
      m_open  = 1'b0;
      m_drain = 1'b0;
      m_cnt   = 0;
      for (int i = 0; i < 8; i++) ex[n+i] = '{default: 0};
    end else begin
      if (was_open) begin
        if (bus.valid_in) begin
          e = ref_calc(cur_smp());
          m_cnt++;
          if (m_cnt == NSC) begin
            e.last  = 1'b1;
            e.done  = 1'b1;
            m_open  = 1'b0;
            m_drain = 1'b1;
            m_end   = n;
            m_syms++;
          end
          ex[n+3] = e;
        end
      end else if (!was_drain && bus.start) begin
        m_open = 1'b1;
        m_cnt  = 0;
      end
      if (was_drain && n == m_end + 4) m_drain = 1'b0;
    end
    ex_busy[n] = m_open || m_drain;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && n > 0) begin
      e = ex[n];
      check("valid_out", longint'(bus.valid_out), longint'(e.v));
      check("last_out",  longint'(bus.last_out),  longint'(e.last));
      check("done",      longint'(bus.done),      longint'(e.done));
      check("busy",      longint'(bus.busy),      longint'(ex_busy[n]));
      check("z_re",      longint'(bus.z_re),      e.v ? e.re  : 64'sd0);
      check("z_im",      longint'(bus.z_im),      e.v ? e.im  : 64'sd0);
      check("pwr",       longint'(bus.pwr),       e.v ? e.pwr : 64'sd0);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  function automatic smp_t mk(input int h0r, h0i, y0r, y0i, h1r, h1i, y1r, y1i);
    smp_t s;
    s.h0r = word_t'(h0r); s.h0i = word_t'(h0i);
    s.y0r = word_t'(y0r); s.y0i = word_t'(y0i);
    s.h1r = word_t'(h1r); s.h1i = word_t'(h1i);
    s.y1r = word_t'(y1r); s.y1i = word_t'(y1i);
    return s;
  endfunction

  function automatic word_t rnd_word();
    case ($urandom_range(0, 3))
      0:       return word_t'($urandom);                         // full range
      1:       return word_t'($signed($urandom_range(0, 1023)) - 512);
      2:       return ($urandom_range(0, 1) != 0) ? word_t'(MAXV) : word_t'(MINV);
      default: return word_t'($signed($urandom_range(0, 8191)) - 4096);
    endcase
  endfunction

  function automatic smp_t rnd_smp();
    smp_t s;
    s.h0r = rnd_word(); s.h0i = rnd_word(); s.y0r = rnd_word(); s.y0i = rnd_word();
    s.h1r = rnd_word(); s.h1i = rnd_word(); s.y1r = rnd_word(); s.y1i = rnd_word();
    return s;
  endfunction

  // Sets inputs on a falling edge; they are sampled at the following rising edge.
  task automatic drive(input bit s, input bit v, input smp_t d);
    @(negedge clk);
    bus.start    = s;
    bus.valid_in = v;
    bus.hc0_re   = d.h0r; bus.hc0_im = d.h0i;
    bus.hc1_re   = d.h1r; bus.hc1_im = d.h1i;
    bus.y0_re    = d.y0r; bus.y0_im  = d.y0i;
    bus.y1_re    = d.y1r; bus.y1_im  = d.y1i;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b0, 1'b0, rnd_smp());
  endtask

  // One accepted sample followed by a gap, then the output is checked against
  // hand-computed values right after the third edge following acceptance.
  task automatic directed(input string tag, input smp_t s,
                          input longint re, input longint im, input longint pw);
    drive(1'b0, 1'b1, s);
    idle(3);
    @(posedge clk);
    #1;
    check({tag, ".valid"}, longint'(bus.valid_out), 64'sd1);
    check({tag, ".z_re"},  longint'(bus.z_re), re);
    check({tag, ".z_im"},  longint'(bus.z_im), im);
    check({tag, ".pwr"},   longint'(bus.pwr),  pw);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".z_re"},      longint'(bus.z_re),      64'sd0);
    check({tag, ".z_im"},      longint'(bus.z_im),      64'sd0);
    check({tag, ".pwr"},       longint'(bus.pwr),       64'sd0);
    check({tag, ".valid_out"}, longint'(bus.valid_out), 64'sd0);
    check({tag, ".last_out"},  longint'(bus.last_out),  64'sd0);
    check({tag, ".busy"},      longint'(bus.busy),      64'sd0);
    check({tag, ".done"},      longint'(bus.done),      64'sd0);
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  smp_t zero_s;

  initial begin
    zero_s = mk(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.valid_in = 1'b0;
    bus.hc0_re = '0; bus.hc0_im = '0; bus.hc1_re = '0; bus.hc1_im = '0;
    bus.y0_re  = '0; bus.y0_im  = '0; bus.y1_re  = '0; bus.y1_im  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Directed symbol; the first sample rides on start and must be dropped.
    drive(1'b1, 1'b1, mk(256, 0, 128, 64, 0, 0, 0, 0));
    directed("basic",  mk(256, 0, 128, 64, 0, 0, 0, 0), 128, 64, 256);
    directed("equal",  mk(256, -256, 256, 256, 256, -256, 256, 256), 1024, 0, 1024);
    directed("satpos", mk(32767, 0, 32767, 32767, 32767, 0, 32767, 32767),
             32767, 32767, 32767);
    directed("satneg", mk(32767, 0, -32767, -32767, 32767, 0, -32767, -32767),
             -32768, -32768, 32767);
    idle(4);

    // Gapped symbol, stray start inside RUN, stray valid right after the last.
    drive(1'b1, 1'b0, zero_s);
    drive(1'b0, 1'b1, rnd_smp());
    drive(1'b0, 1'b1, rnd_smp());
    drive(1'b1, 1'b0, rnd_smp());
    drive(1'b0, 1'b0, rnd_smp());
    drive(1'b0, 1'b1, rnd_smp());
    drive(1'b0, 1'b1, rnd_smp());
    drive(1'b0, 1'b1, rnd_smp());
    drive(1'b1, 1'b1, rnd_smp());
    idle(8);

    // Reset after the second accepted sample of a symbol.
    drive(1'b1, 1'b0, zero_s);
    drive(1'b0, 1'b1, rnd_smp());
    drive(1'b0, 1'b1, rnd_smp());
    @(negedge clk);
    #1 rst = 1'b1;
    bus.valid_in = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    idle(6);
    drive(1'b1, 1'b0, zero_s);
    for (int i = 0; i < NSC; i++) drive(1'b0, 1'b1, rnd_smp());
    idle(8);

    // Randomized traffic: starts, valids and gaps in any state.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0, rnd_smp());
    end
    idle(10);
    check("symbols_completed_min", longint'(m_syms >= 50), 64'sd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
